unsigned_shift_multiplier: RTL and testbench



---
 rtl/mul_pkg.sv | 13 +
 rtl/mul_product_reg.sv | 38 +++
 rtl/unsigned_shift_multiplier.sv | 125 ++++++++++++
 tb/tb_unsigned_shift_multiplier.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and sizing for the sequential shift-add multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

endpackage

// File: rtl/mul_product_reg.sv
// Product register for the shift-add multiplier: {carry, upper, lower}, 2*WIDTH+1 bits.
// The upper half accumulates partial sums while the lower half shifts out multiplier bits.
module mul_product_reg
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_value,
    input  logic               add_shift,
    input  logic               shift_only,
    input  logic [WIDTH-1:0]   sum,
    input  logic               carry,
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH:0] preg;

    // Load, add-then-shift or plain shift; the carry slot drops into the upper MSB on each shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            preg <= {(2*WIDTH+1){1'b0}};
        end else if (load) begin
            preg <= {1'b0, {WIDTH{1'b0}}, load_value};
        end else if (add_shift) begin
            preg <= {1'b0, carry, sum, preg[WIDTH-1:1]};
        end else if (shift_only) begin
            preg <= {1'b0, preg[2*WIDTH], preg[2*WIDTH-1:WIDTH], preg[WIDTH-1:1]};
        end else begin
            preg <= preg;
        end
    end

    assign product = preg[2*WIDTH-1:0];

endmodule

// File: rtl/unsigned_shift_multiplier.sv
// Sequential unsigned WIDTH x WIDTH -> 2*WIDTH multiplier, one multiplier bit per clock.
// Optional macro MUL_ZERO_SKIP_EN: a zero operand finishes after a single RUN cycle.
module unsigned_shift_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               rdy,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_BITS-1:0] LAST_COUNT = CNT_BITS'(WIDTH - 1);

    state_t              state;
    logic [WIDTH-1:0]    mcand;
    logic [CNT_BITS-1:0] count;
    logic                accept;
    logic                step;
    logic                last;
    logic                zero;
    logic [WIDTH:0]      sum;
    logic [WIDTH-1:0]    load_value;
    logic                add_shift;
    logic                shift_only;
`ifdef MUL_ZERO_SKIP_EN
    logic                skip;
`endif

    // Datapath control and the WIDTH+1-bit adder feeding the product register.
    always_comb begin
        accept     = start && (state != RUN);
        step       = (state == RUN);
        sum        = {1'b0, product[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
`ifdef MUL_ZERO_SKIP_EN
        zero       = (multiplicand == {WIDTH{1'b0}}) || (multiplier == {WIDTH{1'b0}});
        last       = (count == LAST_COUNT) || skip;
`else
        zero       = 1'b0;
        last       = (count == LAST_COUNT);
`endif
        if (zero) begin
            load_value = {WIDTH{1'b0}};
        end else begin
            load_value = multiplier;
        end
        add_shift  = step && product[0];
        shift_only = step && !product[0];
    end

    // Controller: operand capture, step counter and registered busy/rdy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            rdy   <= 1'b0;
            mcand <= {WIDTH{1'b0}};
            count <= {CNT_BITS{1'b0}};
`ifdef MUL_ZERO_SKIP_EN
            skip  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    rdy <= 1'b0;
                    if (accept) begin
                        mcand <= multiplicand;
                        count <= {CNT_BITS{1'b0}};
                        state <= RUN;
                        busy  <= 1'b1;
`ifdef MUL_ZERO_SKIP_EN
                        skip  <= zero;
`endif
                    end else begin
                        state <= state;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    count <= count + {{(CNT_BITS-1){1'b0}}, 1'b1};
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        rdy   <= 1'b1;
                    end else begin
                        state <= RUN;
                        busy  <= 1'b1;
                        rdy   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    rdy   <= 1'b0;
                end
            endcase
        end
    end

    mul_product_reg #(
        .WIDTH (WIDTH)
    ) u_product_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (accept),
        .load_value (load_value),
        .add_shift  (add_shift),
        .shift_only (shift_only),
        .sum        (sum[WIDTH-1:0]),
        .carry      (sum[WIDTH]),
        .product    (product)
    );

    assign hi = product[2*WIDTH-1:WIDTH];
    assign lo = product[WIDTH-1:0];

endmodule

// File: tb/tb_unsigned_shift_multiplier.sv
// Directed bench for unsigned_shift_multiplier with a queue-based result scoreboard.
module tb_unsigned_shift_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        rdy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] product;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] sb[$];
    logic [63:0] mon_exp;
    int          n;
    int          zero_lat;

    unsigned_shift_multiplier #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .rdy          (rdy),
        .hi           (hi),
        .lo           (lo),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Drives start for one cycle; the sampling posedge is edge k, and n counts edges since k.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit push);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        if (push) sb.push_back(64'(a) * 64'(b));
        @(negedge clk);
        start = 1'b0;
        n = 0;
    endtask

    task automatic wait_rdy(input int exp_lat);
        while (!rdy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rdy_seen", {63'd0, rdy}, 64'd1);
        check("latency", 64'(n), 64'(exp_lat));
        check("busy_at_rdy", {63'd0, busy}, 64'd0);
    endtask

    // Scoreboard: every rdy pulse consumes one expected product.
    always @(negedge clk) begin
        if (!rst && rdy) begin
            if (sb.size() == 0) begin
                check("unexpected_rdy", 64'd1, 64'd0);
            end else begin
                mon_exp = sb.pop_front();
                check("product", product, mon_exp);
                check("hi", {32'd0, hi}, {32'd0, mon_exp[63:32]});
                check("lo", {32'd0, lo}, {32'd0, mon_exp[31:0]});
            end
        end
    end

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        multiplicand = 32'd0;
        multiplier   = 32'd0;
        n            = 0;
        repeat (3) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_rdy", {63'd0, rdy}, 64'd0);
        check("reset_product", product, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 3 x 5, then confirm the pulse is single-cycle and the result holds
        start_op(32'd3, 32'd5, 1'b1);
        check("busy_after_start", {63'd0, busy}, 64'd1);
        wait_rdy(32);
        @(negedge clk);
        check("rdy_single_pulse", {63'd0, rdy}, 64'd0);
        check("product_hold", product, 64'h0000_0000_0000_000F);
        @(negedge clk);

        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_rdy(32);
        @(negedge clk);

        // Back-to-back: the next start lands in the DONE cycle
        start_op(32'h8000_0000, 32'd2, 1'b1);
        wait_rdy(32);
        start_op(32'd7, 32'd6, 1'b1);
        check("b2b_busy", {63'd0, busy}, 64'd1);
        wait_rdy(32);
        @(negedge clk);

        // A start pulse during RUN must be ignored
        start_op(32'd10, 32'd10, 1'b1);
        repeat (4) begin
            @(negedge clk);
            n++;
        end
        multiplicand = 32'd1;
        multiplier   = 32'd1;
        start        = 1'b1;
        @(negedge clk);
        n++;
        start = 1'b0;
        wait_rdy(32);
        @(negedge clk);

        // Reset while count is 10 aborts the operation
        start_op(32'd9, 32'd9, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_rdy", {63'd0, rdy}, 64'd0);
        check("abort_product", product, 64'd0);
        start_op(32'd4, 32'd4, 1'b1);
        wait_rdy(32);
        @(negedge clk);

`ifdef MUL_ZERO_SKIP_EN
        zero_lat = 1;
`else
        zero_lat = 32;
`endif
        start_op(32'd0, 32'h0000_1234, 1'b1);
        wait_rdy(zero_lat);
        repeat (2) @(negedge clk);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
